// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, mispredict/redirect and perf counters
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_f_pc -> o_pred_taken/target  combinational fetch-side lookup
//   i_ex_*                         resolved branch from execute, trains the table
//   o_mispredict, o_redirect_pc    same-cycle redirect to PC/flush logic
//   o_br_count, o_mp_count         saturating branch and mispredict counters
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_f_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_ex_valid,
  input  logic [31:0] i_ex_pc,
  input  logic [2:0]  i_ex_branch_type,
  input  logic        i_ex_branch_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_br_count,
  output logic [31:0] o_mp_count
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [31:0]       r_target [ENTRIES];
  logic [1:0]        r_ctr    [ENTRIES];
  logic [31:0]       r_br_count, r_mp_count;
  logic [IDX_W-1:0]  w_f_idx, w_ex_idx;
  logic              w_f_hit, w_ex_hit, w_is_br, w_jump, w_upd, w_mp, w_unused;
  logic [1:0]        w_ctr;
  logic [1:0]        w_ctr_nxt;
  assign w_unused = ^{i_f_pc[1:0], i_ex_pc[1:0]};
  assign w_f_idx  = i_f_pc[IDX_W+1:2];
  assign w_ex_idx = i_ex_pc[IDX_W+1:2];
  assign w_f_hit  = r_valid[w_f_idx] && r_tag[w_f_idx] == i_f_pc[31:IDX_W+2];
  assign w_ex_hit = r_valid[w_ex_idx] && r_tag[w_ex_idx] == i_ex_pc[31:IDX_W+2];
  assign o_pred_taken  = w_f_hit && r_ctr[w_f_idx][1];
  assign o_pred_target = w_f_hit ? r_target[w_f_idx] : i_f_pc + 32'd4;
  assign w_is_br = |i_ex_branch_type;
  assign w_jump  = &i_ex_branch_type;
  assign w_ctr   = r_ctr[w_ex_idx];
  // A miss allocates only for taken branches or jumps; hits always retrain
  assign w_upd = w_is_br && (w_ex_hit || i_ex_branch_taken || w_jump);
  assign w_ctr_nxt = w_jump ? 2'b11 :
                     !w_ex_hit ? 2'b10 :
                     i_ex_branch_taken ? (w_ctr == 2'b11 ? w_ctr : w_ctr + 2'd1) :
                     (w_ctr == 2'b00 ? w_ctr : w_ctr - 2'd1);
  assign w_mp = i_ex_valid && (w_is_br ?
                (i_ex_branch_taken != i_ex_pred_taken ||
                 (i_ex_branch_taken && i_ex_target != i_ex_pred_target)) :
                i_ex_pred_taken);
  assign o_mispredict  = w_mp;
  assign o_redirect_pc = (w_is_br && i_ex_branch_taken) ? i_ex_target : i_ex_pc + 32'd4;
  assign o_br_count    = r_br_count;
  assign o_mp_count    = r_mp_count;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
      r_br_count <= '0;
      r_mp_count <= '0;
    end else if (i_ex_valid) begin
      if (w_upd) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= i_ex_pc[31:IDX_W+2];
        r_ctr[w_ex_idx]    <= w_ctr_nxt;
        r_target[w_ex_idx] <= (i_ex_branch_taken || !w_ex_hit) ? i_ex_target : r_target[w_ex_idx];
      end else if (!w_is_br && w_ex_hit && i_ex_pred_taken) begin
        // a non-branch predicted taken means an aliased entry; drop it
        r_valid[w_ex_idx] <= 1'b0;
      end
      r_br_count <= r_br_count + 32'(w_is_br && r_br_count != '1);
      r_mp_count <= r_mp_count + 32'(w_mp && r_mp_count != '1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed plan plus randomized traffic against a behavioural BTB model
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int IW = $clog2(ENTRIES);
  logic clk = 0;
  always #5 clk = ~clk;
  logic        rst_n, f_valid_unused;
  logic [31:0] f_pc, ex_pc, ex_target, ex_pred_target;
  logic        ex_valid, ex_branch_taken, ex_pred_taken;
  logic [2:0]  ex_branch_type;
  logic        pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc, br_count, mp_count;
  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_f_pc(f_pc),
    .o_pred_taken(pred_taken), .o_pred_target(pred_target),
    .i_ex_valid(ex_valid), .i_ex_pc(ex_pc), .i_ex_branch_type(ex_branch_type),
    .i_ex_branch_taken(ex_branch_taken), .i_ex_target(ex_target),
    .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_target(ex_pred_target),
    .o_mispredict(mispredict), .o_redirect_pc(redirect_pc),
    .o_br_count(br_count), .o_mp_count(mp_count)
  );
  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  // Model: each slot remembers the full PC of the branch that owns it
  bit          m_v   [ENTRIES];
  logic [31:0] m_pc  [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_ctr [ENTRIES];
  longint      m_br, m_mp;
  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction
  function automatic bit m_hit(input logic [31:0] pc);
    int s = slot(pc);
    return m_v[s] && (m_pc[s] >> (IW + 2)) == (pc >> (IW + 2));
  endfunction
  function automatic bit m_pt(input logic [31:0] pc);
    return m_hit(pc) && m_ctr[slot(pc)] >= 2;
  endfunction
  function automatic logic [31:0] m_ptg(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[slot(pc)] : pc + 4;
  endfunction
  function automatic bit m_mispred();
    if (!ex_valid) return 0;
    if (ex_branch_type == 0) return ex_pred_taken;
    return ex_branch_taken != ex_pred_taken || (ex_branch_taken && ex_target != ex_pred_target);
  endfunction
  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_v[i] = 0; m_pc[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0; m_mp = 0;
  endtask
  task automatic m_update();
    bit h, mp;
    int s;
    if (!rst_n) begin
      m_reset();
      return;
    end
    if (!ex_valid) return;
    s = slot(ex_pc);
    h = m_hit(ex_pc);
    mp = m_mispred();
    if (ex_branch_type != 0) begin
      if (h || ex_branch_taken || ex_branch_type == 7) begin
        if (ex_branch_type == 7) m_ctr[s] = 3;
        else if (!h) m_ctr[s] = 2;
        else if (ex_branch_taken) m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
        else m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        if (ex_branch_taken || !h) m_tgt[s] = ex_target;
        m_v[s] = 1;
        m_pc[s] = ex_pc;
      end
      if (m_br < 64'hFFFF_FFFF) m_br++;
    end else if (h && ex_pred_taken) m_v[s] = 0;
    if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
  endtask
  task automatic drive(input bit rs, input logic [31:0] f, input bit v, input logic [31:0] pc,
                       input logic [2:0] ty, input bit tk, input logic [31:0] tg,
                       input bit pt, input logic [31:0] ptg);
    @(negedge clk);
    rst_n = rs; f_pc = f; ex_valid = v; ex_pc = pc; ex_branch_type = ty;
    ex_branch_taken = tk; ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
    #1;
    check("pred_taken", 32'(pred_taken), 32'(m_pt(f)));
    check("pred_target", pred_target, m_ptg(f));
    check("mispredict", 32'(mispredict), 32'(m_mispred()));
    check("redirect_pc", redirect_pc, (ty != 0 && tk) ? tg : pc + 4);
    check("br_count", br_count, m_br[31:0]);
    check("mp_count", mp_count, m_mp[31:0]);
  endtask
  task automatic tick();
    @(posedge clk);
    m_update();
  endtask
  initial begin
    logic [31:0] pc, f, tg, ptg;
    logic [2:0] ty;
    bit tk, pt;
    f_valid_unused = 0;
    rst_n = 0; f_pc = 0; ex_valid = 0; ex_pc = 0; ex_branch_type = 0;
    ex_branch_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    @(posedge clk);
    m_reset();
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pt", 32'(pred_taken), 0);
    check("rst_ptg", pred_target, 32'h104);
    check("rst_br", br_count, 0);
    check("rst_mp", mp_count, 0);
    tick();
    drive(1, 32'h100, 1, 32'h100, 1, 1, 32'h200, 0, 32'h104);
    check("beq_mp", 32'(mispredict), 1);
    check("beq_rd", redirect_pc, 32'h200);
    tick();
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    check("train_pt", 32'(pred_taken), 1);
    check("train_ptg", pred_target, 32'h200);
    check("train_mpc", mp_count, 1);
    tick();
    drive(1, 32'h100, 1, 32'h100, 1, 0, 32'h200, 1, 32'h200);
    check("nt1_mp", 32'(mispredict), 1);
    check("nt1_rd", redirect_pc, 32'h104);
    tick();
    drive(1, 32'h100, 1, 32'h100, 1, 0, 32'h200, 0, 32'h104);
    check("nt2_pt", 32'(pred_taken), 0);
    check("nt2_mp", 32'(mispredict), 0);
    tick();
    drive(1, 32'h100, 1, 32'h100, 1, 0, 32'h200, 0, 32'h104);
    tick();
    drive(1, 32'h100, 1, 32'h100, 1, 1, 32'h200, 0, 32'h104);
    tick();
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    check("sat0_pt", 32'(pred_taken), 0);
    tick();
    drive(1, 32'h40, 1, 32'h40, 7, 1, 32'h80, 0, 32'h44);
    tick();
    drive(1, 32'h40, 1, 32'h40, 7, 1, 32'h90, 1, 32'h80);
    check("jal_pt", 32'(pred_taken), 1);
    check("jal_ptg", pred_target, 32'h80);
    check("jal_mp", 32'(mispredict), 1);
    check("jal_rd", redirect_pc, 32'h90);
    tick();
    drive(1, 32'h40, 1, 32'h100, 1, 1, 32'h200, 0, 32'h104);
    check("jal_tgt", pred_target, 32'h90);
    tick();
    drive(1, 32'h140, 1, 32'h100, 0, 0, 0, 1, 32'h200);
    check("alias_pt", 32'(pred_taken), 0);
    check("alias_ptg", pred_target, 32'h144);
    check("alias_mp", 32'(mispredict), 1);
    check("alias_rd", redirect_pc, 32'h104);
    tick();
    drive(1, 32'h100, 0, 32'h300, 1, 1, 32'h400, 0, 32'h304);
    check("inval_pt", 32'(pred_taken), 0);
    check("inval_ptg", pred_target, 32'h104);
    check("exv0_mp", 32'(mispredict), 0);
    tick();
    drive(0, 32'h300, 1, 32'h300, 1, 1, 32'h400, 0, 32'h304);
    check("exv0_pt", 32'(pred_taken), 0);
    tick();
    drive(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
    check("rstupd_pt", 32'(pred_taken), 0);
    check("rstupd_ptg", pred_target, 32'h304);
    check("rstupd_br", br_count, 0);
    check("rstupd_mp", mp_count, 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      pc = 32'h100 + 4 * $urandom_range(0, 47) + ($urandom_range(0, 3) == 0 ? 32'h1000 : 0);
      f  = 32'h100 + 4 * $urandom_range(0, 47) + ($urandom_range(0, 3) == 0 ? 32'h1000 : 0);
      ty = 3'($urandom_range(0, 7));
      tk = (ty == 7) ? 1 : 1'($urandom_range(0, 1));
      tg = 32'h2000 + 4 * $urandom_range(0, 7);
      if ($urandom_range(0, 9) < 7) begin
        pt = m_pt(pc); ptg = m_ptg(pc);
      end else begin
        pt = 1'($urandom_range(0, 1)); ptg = 32'h2000 + 4 * $urandom_range(0, 7);
      end
      drive($urandom_range(0, 99) != 0, f, $urandom_range(0, 9) < 8, pc, ty, tk, tg, pt, ptg);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
